// File: rtl/image_filter_stream.sv
// Streaming 3x3 image filter: pass-through, 3x3 box blur, luminance threshold
// and saturating brightness offset on an RGB raster stream. Two line buffers
// feed a 3x3 window; each output leaves a register one cycle after the input
// handshake that completes its window, and the final WIDTH+1 outputs are
// drained from the buffered bottom row after the last input pixel.
module image_filter_stream #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int DW        = 8,
    parameter int VALUE     = 100,
    parameter int THRESHOLD = 90
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [1:0]    mode,
    input  logic          sign,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_r,
    input  logic [DW-1:0] s_g,
    input  logic [DW-1:0] s_b,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_r,
    output logic [DW-1:0] m_g,
    output logic [DW-1:0] m_b,
    output logic          m_eol,
    output logic          m_eof,
    output logic          frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int SW = DW + 4;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    localparam logic [DW-1:0]        PIX_MAX   = {DW{1'b1}};
    localparam logic signed [DW+1:0] PIX_MAX_S = $signed({2'b00, PIX_MAX});
    localparam logic signed [DW+1:0] OFFSET    = (DW+2)'(VALUE);
    localparam logic [DW+1:0]        THR_LVL   = (DW+2)'(THRESHOLD);

    // Brightness offset, clamped to the pixel range in both directions.
    function automatic logic [DW-1:0] sat_bright(input logic [DW-1:0] p, input logic add);
        logic signed [DW+1:0] t;
        t = add ? ($signed({2'b00, p}) + OFFSET) : ($signed({2'b00, p}) - OFFSET);
        if (t[DW+1])
            return '0;
        else if (t > PIX_MAX_S)
            return PIX_MAX;
        else
            return t[DW-1:0];
    endfunction

    // Nine-tap average, truncated; the quotient always fits DW bits.
    function automatic logic [DW-1:0] box_div9(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = s / SW'(9);
        return q[DW-1:0];
    endfunction

    // Truncated mean of the three channels compared against the threshold.
    function automatic logic above_thr(input logic [DW-1:0] r, input logic [DW-1:0] g,
                                       input logic [DW-1:0] b);
        logic [DW+1:0] s;
        logic [DW+1:0] avg;
        s   = {2'b00, r} + {2'b00, g} + {2'b00, b};
        avg = s / (DW+2)'(3);
        return avg > THR_LVL;
    endfunction

    // Channel index 0/1/2 = R/G/B throughout.
    logic [DW-1:0] lb0 [3][WIDTH];   // previous line
    logic [DW-1:0] lb1 [3][WIDTH];   // line before that
    logic [DW-1:0] win [3][3][2];    // [ch][row top/mid/bot][col left/centre]

    logic [1:0]    state;
    logic [1:0]    mode_q;
    logic          sign_q;
    logic [CW-1:0] in_col;
    logic [RW-1:0] in_row;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;
    logic          last_made;

    logic          in_hs;
    logic          out_free;
    logic          flush_step;
    logic          step;
    logic          produce;
    logic          fill_done;
    logic          in_last;
    logic          fr_end;
    logic          border;
    logic          thr_hit;

    logic [DW-1:0] s_in    [3];
    logic [DW-1:0] col_top [3];
    logic [DW-1:0] col_mid [3];
    logic [DW-1:0] col_bot [3];
    logic [SW-1:0] sum     [3];
    logic [DW-1:0] res     [3];

    assign out_free   = !m_valid || m_ready;
    assign s_ready    = HRESETn && (state != FLUSH) && out_free;
    assign in_hs      = s_valid && s_ready;
    assign flush_step = (state == FLUSH) && out_free && !last_made;
    assign step       = in_hs || flush_step;
    assign fill_done  = (in_row == RW'(1)) && (in_col == CW'(1));
    assign in_last    = (in_row == ROW_LAST) && (in_col == COL_LAST);
    assign produce    = flush_step ||
                        (in_hs && ((state == RUN) || ((state == FILL) && fill_done)));
    assign fr_end     = m_valid && m_ready && m_eof;
    assign border     = (out_row == '0) || (out_row == ROW_LAST) ||
                        (out_col == '0) || (out_col == COL_LAST);

    // Incoming window column; while draining, the bottom row is replicated.
    always_comb begin
        s_in[0] = s_r;
        s_in[1] = s_g;
        s_in[2] = s_b;
        for (int ch = 0; ch < 3; ch++) begin
            col_top[ch] = lb1[ch][in_col];
            col_mid[ch] = lb0[ch][in_col];
            col_bot[ch] = (state == FLUSH) ? lb0[ch][in_col] : s_in[ch];
        end
    end

    // Per-channel 3x3 sum over the two held columns plus the incoming one.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            sum[ch] = SW'(col_top[ch]) + SW'(col_mid[ch]) + SW'(col_bot[ch]);
            for (int r = 0; r < 3; r++)
                sum[ch] = sum[ch] + SW'(win[ch][r][0]) + SW'(win[ch][r][1]);
        end
    end

    // Mode select; the output centre is always the middle of the held centre column.
    always_comb begin
        thr_hit = above_thr(win[0][1][1], win[1][1][1], win[2][1][1]);
        for (int ch = 0; ch < 3; ch++) begin
            res[ch] = win[ch][1][1];
            case (mode_q)
                2'd0:    res[ch] = win[ch][1][1];
                2'd1:    res[ch] = border ? win[ch][1][1] : box_div9(sum[ch]);
                2'd2:    res[ch] = thr_hit ? PIX_MAX : '0;
                default: res[ch] = sat_bright(win[ch][1][1], sign_q);
            endcase
        end
    end

    // Line buffers and window shift on every input or drain step (data only, no reset).
    always_ff @(posedge HCLK) begin
        if (step) begin
            for (int ch = 0; ch < 3; ch++) begin
                lb1[ch][in_col] <= col_mid[ch];
                lb0[ch][in_col] <= col_bot[ch];
                for (int r = 0; r < 3; r++)
                    win[ch][r][0] <= win[ch][r][1];
                win[ch][0][1] <= col_top[ch];
                win[ch][1][1] <= col_mid[ch];
                win[ch][2][1] <= col_bot[ch];
            end
        end
    end

    // Frame FSM, mode latch and raster counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            sign_q    <= 1'b0;
            in_col    <= '0;
            in_row    <= '0;
            out_col   <= '0;
            out_row   <= '0;
            last_made <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        mode_q <= mode;
                        sign_q <= sign;
                        state  <= FILL;
                    end
                end
                FILL:    if (in_hs && fill_done) state <= RUN;
                RUN:     if (in_hs && in_last)   state <= FLUSH;
                default: if (fr_end)             state <= IDLE;
            endcase

            if (fr_end) begin
                in_col <= '0;
                in_row <= '0;
            end else if (step) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= (in_row == ROW_LAST) ? '0 : in_row + RW'(1);
                end else begin
                    in_col <= in_col + CW'(1);
                end
            end

            if (fr_end) begin
                out_col <= '0;
                out_row <= '0;
            end else if (produce) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end

            if (fr_end)
                last_made <= 1'b0;
            else if (produce && (out_col == COL_LAST) && (out_row == ROW_LAST))
                last_made <= 1'b1;
        end
    end

    // Output register: loads on produce, holds under backpressure.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_valid    <= 1'b0;
            m_r        <= '0;
            m_g        <= '0;
            m_b        <= '0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= fr_end;
            if (produce) begin
                m_valid <= 1'b1;
                m_r     <= res[0];
                m_g     <= res[1];
                m_b     <= res[2];
                m_eol   <= (out_col == COL_LAST);
                m_eof   <= (out_col == COL_LAST) && (out_row == ROW_LAST);
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_eol   <= 1'b0;
                m_eof   <= 1'b0;
            end
        end
    end

endmodule
